// File: rtl/piso_out.sv
// piso_out -- parallel-in/serial-out transmitter.
//
// Captures a w-bit word on an accepted i_en and sends it LSB first as
// start bit (0), w data bits, [optional even-parity bit], stop bit (1).
// Each serial bit is held for DIV clock cycles.
//
// Parameters:
//   w   : data word width (1..16)
//   DIV : clock cycles per serial bit (>= 1)
//
// Ports:
//   clk    : system clock, all state changes on posedge
//   clr_n  : asynchronous active-low reset
//   i_en   : load request, ignored while o_busy is high
//   d      : parallel data, captured when i_en is accepted
//   o_ser  : serial line, idles high (registered)
//   o_busy : high while a frame is in flight (registered)
//   o_done : one-cycle pulse on the last cycle of the stop bit (registered)
//
// Build option:
//   PISO_PARITY_EN : when defined, an even-parity bit (XOR of the captured
//                    word) is sent between the data bits and the stop bit.

module piso_out #(
  parameter int w   = 4,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         i_en,
  input  logic [w-1:0] d,
  output logic         o_ser,
  output logic         o_busy,
  output logic         o_done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(w + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(w - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t         state_q, state_d;
  logic [w-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]  div_q, div_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic           ser_q, ser_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           div_last;
`ifdef PISO_PARITY_EN
  logic           par_q, par_d;
`endif

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    bit_d   = bit_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_en) begin
          shreg_d = d;
          div_d   = '0;
          bit_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^d;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_last) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_last) begin
          div_d   = '0;
          shreg_d = shreg_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_STOP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered line level
  // changes on the same edge as the state it belongs to.
  always_comb begin
    ser_d  = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (div_d == DIV_LAST);
    unique case (state_d)
      S_START:  ser_d = 1'b0;
      S_DATA:   ser_d = shreg_d[0];
`ifdef PISO_PARITY_EN
      S_PARITY: ser_d = par_d;
`endif
      default:  ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_ser  = ser_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_piso_out.sv
module tb_piso_out;

  localparam int W   = 4;
  localparam int DIV = 4;
`ifdef PISO_PARITY_EN
  localparam int NSLOT = 7;
`else
  localparam int NSLOT = 6;
`endif
  localparam int FL = NSLOT * DIV;

  logic         clk;
  logic         clr_n;
  logic         i_en, i_en1;
  logic [W-1:0] d, d1;
  logic         o_ser, o_busy, o_done;
  logic         o_ser1, o_busy1, o_done1;

  int checks = 0;
  int errors = 0;

  piso_out #(.w(W), .DIV(DIV)) dut (
    .clk(clk), .clr_n(clr_n), .i_en(i_en), .d(d),
    .o_ser(o_ser), .o_busy(o_busy), .o_done(o_done)
  );

  piso_out #(.w(W), .DIV(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .i_en(i_en1), .d(d1),
    .o_ser(o_ser1), .o_busy(o_busy1), .o_done(o_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [5:0] ser_np;   // slot i = expected line level, no parity build
    logic [6:0] ser_p;    // slot i = expected line level, parity build
    bit         disturb;  // issue a second i_en (d=4'hc) mid-frame
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] pick(input vec_t v);
`ifdef PISO_PARITY_EN
    return v.ser_p;
`else
    return {1'b0, v.ser_np};
`endif
  endfunction

  task automatic run_frame(input logic [3:0] dv, input logic [6:0] slots,
                           input bit disturb);
    @(negedge clk);
    d = dv; i_en = 1'b1;
    @(posedge clk);
    #1 i_en = 1'b0;
    for (int c = 1; c <= FL; c++) begin
      @(negedge clk);
      if (disturb && c == 6) begin d = 4'hc; i_en = 1'b1; end
      if (disturb && c == 7) i_en = 1'b0;
      chk("frame_ser", o_ser, slots[(c-1)/DIV]);
      chk("frame_busy", o_busy, 1'b1);
      chk("frame_done", o_done, (c == FL) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("after_busy", o_busy, 1'b0);
    chk("after_ser", o_ser, 1'b1);
    chk("after_done", o_done, 1'b0);
  endtask

  initial begin
    logic [6:0] s;
    int dones;

    vecs[0] = '{4'ha, 6'b110100, 7'b1010100, 1'b0};
    vecs[1] = '{4'h3, 6'b100110, 7'b1000110, 1'b0};
    vecs[2] = '{4'h7, 6'b101110, 7'b1101110, 1'b0};
    vecs[3] = '{4'h0, 6'b100000, 7'b1000000, 1'b0};
    vecs[4] = '{4'h1, 6'b100010, 7'b1100010, 1'b0};
    vecs[5] = '{4'hf, 6'b111110, 7'b1011110, 1'b0};
    vecs[6] = '{4'h4, 6'b101000, 7'b1101000, 1'b1};

    i_en = 1'b0; d = '0; i_en1 = 1'b0; d1 = '0;

    // Reset / idle
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ser", o_ser, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    clr_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ser", o_ser, 1'b1);
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_done", o_done, 1'b0);
      chk("idle_ser1", o_ser1, 1'b1);
      chk("idle_busy1", o_busy1, 1'b0);
    end

    // Table-driven frames, including load-while-busy (last entry)
    for (int i = 0; i < 7; i++) run_frame(vecs[i].d, pick(vecs[i]), vecs[i].disturb);

    // Back-to-back: i_en held high with d=4'hf
    s = pick(vecs[5]);
    dones = 0;
    @(negedge clk);
    d = 4'hf; i_en = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2*FL + 1; c++) begin
      @(negedge clk);
      if (c == FL + 2) i_en = 1'b0;
      if (o_done) dones++;
      if (c <= FL) begin
        chk("b2b_ser1", o_ser, s[(c-1)/DIV]);
        chk("b2b_busy1", o_busy, 1'b1);
      end else if (c == FL + 1) begin
        chk("b2b_gap_ser", o_ser, 1'b1);
        chk("b2b_gap_busy", o_busy, 1'b0);
      end else begin
        chk("b2b_ser2", o_ser, s[(c-FL-2)/DIV]);
        chk("b2b_busy2", o_busy, 1'b1);
      end
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", dones);
    end
    @(negedge clk);
    chk("b2b_end_busy", o_busy, 1'b0);
    @(negedge clk);
    chk("b2b_no_third", o_busy, 1'b0);

    // Mid-frame asynchronous reset during data bit 2 of 4'h3
    @(negedge clk);
    d = 4'h3; i_en = 1'b1;
    @(posedge clk);
    #1 i_en = 1'b0;
    repeat (14) @(negedge clk);
    chk("mid_ser_pre", o_ser, 1'b0);
    chk("mid_busy_pre", o_busy, 1'b1);
    #2 clr_n = 1'b0;
    #1;
    chk("mid_rst_ser", o_ser, 1'b1);
    chk("mid_rst_busy", o_busy, 1'b0);
    chk("mid_rst_done", o_done, 1'b0);
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_ser", o_ser, 1'b1);
      chk("post_rst_busy", o_busy, 1'b0);
      chk("post_rst_done", o_done, 1'b0);
    end

    // DIV=1 instance, d=4'h7
    s = pick(vecs[2]);
    @(negedge clk);
    d1 = 4'h7; i_en1 = 1'b1;
    @(posedge clk);
    #1 i_en1 = 1'b0;
    for (int c = 1; c <= NSLOT; c++) begin
      @(negedge clk);
      chk("div1_ser", o_ser1, s[c-1]);
      chk("div1_busy", o_busy1, 1'b1);
      chk("div1_done", o_done1, (c == NSLOT) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    chk("div1_end_busy", o_busy1, 1'b0);
    chk("div1_end_ser", o_ser1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
